w_fetch_seq: RTL and testbench
==============================

W_FETCH_SEQ -- requirements
Module: w_fetch_seq

Interface
REQ-001 SHALL have parameter DATA_ALL, default 96, meaning weight words per mix layer.
REQ-002 SHALL have parameter LAYERS, default 3, meaning number of mix layers stored contiguously in the weight ROM.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-high (asserted at 1).
REQ-006 SHALL have port start  input  1  single-cycle request to begin a fetch.
REQ-007 SHALL have port layer_sel  input  2  0..2 selects one layer; 3 selects all layers back-to-back.
REQ-008 SHALL have port rom_addr  output  16  word address to the weight ROM.
REQ-009 SHALL have port rom_data  input  BIT_LENGTH*DATA_N  ROM read data, valid one cycle after rom_addr.
REQ-010 SHALL have port w_data  output  BIT_LENGTH*DATA_N  weight word to the mix-layer datapath.
REQ-011 SHALL have port w_valid  output  1  w_data holds a valid word.
REQ-012 SHALL have port w_ready  input  1  consumer accepts; transfer when w_valid and w_ready are both high.
REQ-013 SHALL have port w_last  output  1  high with the final word of the fetch.
REQ-014 SHALL have port w_idx  output  7  index of the current word within its layer, 0..DATA_ALL-1.
REQ-015 SHALL have port busy  output  1  fetch in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-018 IDLE: start=1 with layer_sel=L SHALL load base=(L==3 ? 0 : L*DATA_ALL) and count=(L==3 ? LAYERS*DATA_ALL : DATA_ALL), then enter RUN.
REQ-019 start SHALL be ignored when not in IDLE.
REQ-020 RUN: at most one address SHALL be issued per cycle, and only when fifo_count + inflight - pop < FIFO_DEPTH.
REQ-021 inflight SHALL be 1 in the cycle after an issue and 0 otherwise.
REQ-022 Each issued address SHALL be the previous one + 1, starting at base.
REQ-023 After issuing address base+count-1, the FSM SHALL enter DRAIN; rom_addr SHALL hold its last value.
REQ-024 The ROM word SHALL be written into the FIFO one cycle after its address was issued.
REQ-025 Latency: start sampled at edge E0 gives rom_addr=base after E0, rom_data after E1, and w_valid=1 with word 0 after E2.
REQ-026 With w_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-027 w_valid low with w_ready high SHALL cause no state change.
REQ-028 w_data, w_idx and w_last SHALL be stable while w_valid=1 and w_ready=0.
REQ-029 The FIFO SHALL never overflow or underflow for any w_ready pattern.
REQ-030 w_idx SHALL count 0..DATA_ALL-1 and wrap to 0 at each layer boundary (layer_sel=3 gives 0..95 three times).
REQ-031 w_last SHALL be high only for word count-1.
REQ-032 DRAIN: when the w_last word transfers, done SHALL pulse high for the next cycle and the FSM SHALL return to IDLE.
REQ-033 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-034 start may be accepted in the cycle done is high.
REQ-035 Address arithmetic SHALL be 16-bit unsigned; the highest address is LAYERS*DATA_ALL-1 = 287.

Reset
REQ-036 rst_n=1 at a rising edge SHALL force IDLE, clear the FIFO and inflight, and set rom_addr=0, w_valid=0, w_last=0, w_idx=0, busy=0, done=0.
REQ-037 Reset mid-fetch SHALL discard all pending words, and the cycle after reset release SHALL show w_valid=0.
REQ-038 w_data need not be reset.

Structure
REQ-039 BIT_LENGTH, DATA_N and DATA_ALL SHALL come from the shared num_data.v definitions, and state encodings SHALL be local parameters.
REQ-040 The output buffer SHALL be one sub-module, w_fetch_fifo: synchronous FIFO_DEPTH-entry FIFO with count output and first-word-fall-through.
REQ-041 The ROM SHALL be external to this block.

Verification
REQ-042 layer_sel=1, w_ready=1 -> rom_addr 96..191; w_valid after 3 edges; 96 consecutive words; w_last at w_idx=95; done one cycle later.
REQ-043 layer_sel=3 -> 288 words from addresses 0..287; w_idx wraps at 96 and 192; w_last only at word 287.
REQ-044 w_ready random at 50%, layer 0 -> every word equals the ROM model content in order, no drops or duplicates, and FIFO count stays ≤ 2.
REQ-045 w_ready=0 for 10 cycles mid-fetch -> issue stops; w_data, w_idx and w_last are held; the stream resumes without a gap.
REQ-046 start pulsed while busy -> ignored, with the stream unchanged; start in the done cycle -> the new fetch starts.
REQ-047 rst_n=1 at word 40 -> next cycle w_valid=0, busy=0, rom_addr=0; a following start of layer 2 streams 192..287 correctly.

Source files
------------

// File: rtl/w_fetch_seq_pkg.sv
// w_fetch_seq_pkg
//   Shared word geometry for the weight fetch path (the num_data definitions:
//   BIT_LENGTH, DATA_N, DATA_ALL) plus the address and index widths used by
//   the fetch sequencer and its stream interface.
package w_fetch_seq_pkg;

  localparam int BIT_LENGTH    = 8;
  localparam int DATA_N        = 4;
  localparam int DATA_ALL_DFLT = 96;

  localparam int W_WIDTH = BIT_LENGTH * DATA_N;
  localparam int ADDR_W  = 16;
  localparam int IDX_W   = 7;

  typedef logic [W_WIDTH-1:0] word_t;
  typedef logic [ADDR_W-1:0]  addr_t;

endpackage

// File: rtl/w_fetch_seq_if.sv
// w_fetch_seq_if
//   Valid/ready weight stream from the fetch sequencer to the mix-layer
//   datapath.
//     w_data  : weight word
//     w_valid : w_data holds a valid word
//     w_ready : consumer accepts (transfer when w_valid & w_ready)
//     w_last  : final word of the fetch
//     w_idx   : index of the word within its layer
//   master = sequencer side, slave = datapath side.
interface w_fetch_seq_if;
  import w_fetch_seq_pkg::*;

  word_t            w_data;
  logic             w_valid;
  logic             w_ready;
  logic             w_last;
  logic [IDX_W-1:0] w_idx;

  modport master (output w_data, output w_valid, output w_last, output w_idx,
                  input  w_ready);
  modport slave  (input  w_data, input  w_valid, input  w_last, input  w_idx,
                  output w_ready);

endinterface

// File: rtl/w_fetch_fifo.sv
// w_fetch_fifo
//   Synchronous first-word-fall-through FIFO used as the output buffer of the
//   weight fetch sequencer.
//     clk, rst  : clock, synchronous active-high reset
//     push      : write push_data this cycle
//     pop       : head is consumed this cycle (only when valid)
//     pop_data  : current head word (valid when valid=1)
//     valid     : FIFO not empty
//     count     : number of stored entries, 0..DEPTH
//   The caller guarantees no push when full without a simultaneous pop.
module w_fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; contents are only observed through valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign valid    = (count != '0);

endmodule

// File: rtl/w_fetch_seq.sv
// w_fetch_seq
//   Streams weight words for one mix layer (or all layers back-to-back) from
//   an external synchronous weight ROM to the mix-layer datapath.
//     clk       : clock, rising edge
//     rst_n     : synchronous reset, active HIGH despite the name
//     start     : one-cycle fetch request, honoured only in IDLE
//     layer_sel : 0..2 one layer, 3 all layers
//     rom_addr  : ROM word address (ROM returns data one cycle later)
//     rom_data  : ROM read data
//     w_out     : weight stream (data/valid/ready/last/idx)
//     busy      : fetch in progress
//     done      : one-cycle pulse after the final word transfers
//
//   state | meaning
//   IDLE  | waiting for start, rom_addr holds last issued address
//   RUN   | issuing ROM addresses as buffer credit allows
//   DRAIN | all addresses issued, waiting for the last word to transfer
module w_fetch_seq
  import w_fetch_seq_pkg::*;
#(
  parameter int DATA_ALL   = DATA_ALL_DFLT,
  parameter int LAYERS     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          layer_sel,
  output addr_t               rom_addr,
  input  word_t               rom_data,
  w_fetch_seq_if.master       w_out,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam addr_t            LAYER_WORDS = ADDR_W'(DATA_ALL);
  localparam addr_t            ALL_WORDS   = ADDR_W'(LAYERS * DATA_ALL);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_ALL - 1);
  localparam logic [CNT_W:0]   DEPTH_V     = (CNT_W + 1)'(FIFO_DEPTH);

  logic [1:0]       state;
  addr_t            nxt_addr;
  addr_t            last_addr;
  addr_t            iss_left;
  addr_t            out_left;
  logic [IDX_W-1:0] out_idx;
  logic             inflight;
  logic             done_q;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  word_t            fifo_head;

  logic             pop;
  logic             issue;
  logic             last_word;
  logic [CNT_W:0]   occ;
  logic [CNT_W:0]   lim;
  addr_t            start_base;
  addr_t            start_count;

  assign pop       = fifo_valid & w_out.w_ready;
  assign last_word = fifo_valid && (out_left == 16'd1);

  // Credit check: words buffered plus the one whose ROM read is in flight,
  // minus the one leaving this cycle, must leave room for one more.
  assign occ   = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign lim   = DEPTH_V + (CNT_W + 1)'(pop);
  assign issue = (state == ST_RUN) && (occ < lim);

  // The address is presented in the issue cycle so the ROM's registered read
  // lands one cycle later; otherwise the last issued address is held.
  assign rom_addr = issue ? nxt_addr : last_addr;

  assign start_base  = (layer_sel == 2'd3) ? '0 : ADDR_W'(layer_sel) * LAYER_WORDS;
  assign start_count = (layer_sel == 2'd3) ? ALL_WORDS : LAYER_WORDS;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      nxt_addr  <= '0;
      last_addr <= '0;
      iss_left  <= '0;
      out_left  <= '0;
      out_idx   <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= pop && last_word;

      if (issue) begin
        last_addr <= nxt_addr;
        nxt_addr  <= nxt_addr + 16'd1;
        iss_left  <= iss_left - 16'd1;
      end

      if (pop) begin
        out_left <= out_left - 16'd1;
        out_idx  <= (out_idx == IDX_LAST) ? '0 : out_idx + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            nxt_addr <= start_base;
            iss_left <= start_count;
            out_left <= start_count;
            out_idx  <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue && (iss_left == 16'd1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && last_word) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  w_fetch_fifo #(
    .WIDTH (W_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (inflight),
    .push_data (rom_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign w_out.w_data  = fifo_head;
  assign w_out.w_valid = fifo_valid;
  assign w_out.w_last  = last_word;
  assign w_out.w_idx   = out_idx;

  assign busy = (state != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_w_fetch_seq.sv
// tb_w_fetch_seq
//   Directed bench for w_fetch_seq with a synchronous ROM model whose
//   contents are a fixed function of the address.
module tb_w_fetch_seq;
  import w_fetch_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  layer_sel;
  addr_t       rom_addr;
  word_t       rom_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  w_fetch_seq_if wif();

  w_fetch_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer_sel (layer_sel),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .w_out     (wif),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t rom_fn(input addr_t a);
    return {a ^ 16'h3C00, ~a};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; layer_sel = 2'd0; wif.w_ready = 1'b1;
    cyc(); cyc(); cyc();
    total++; if (wif.w_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", wif.w_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (rom_addr !== 16'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", rom_addr); end
    total++; if (wif.w_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", wif.w_last); end
    total++; if (wif.w_idx !== 7'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", wif.w_idx); end
    rst_n = 1'b0;
    cyc();
    total++; if (wif.w_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_release valid=%b busy=%b exp=0,0", wif.w_valid, busy); end
  endtask

  task automatic test_layer1();
    start = 1'b1; layer_sel = 2'd1; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    total++; if (rom_addr !== 16'd96) begin bad++; $display("FAIL l1_addr0 got=%0d exp=96", rom_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL l1_busy got=%b exp=1", busy); end
    total++; if (wif.w_valid !== 1'b0) begin bad++; $display("FAIL l1_lat1 valid=%b exp=0", wif.w_valid); end
    cyc();
    total++; if (rom_addr !== 16'd97) begin bad++; $display("FAIL l1_addr1 got=%0d exp=97", rom_addr); end
    total++; if (wif.w_valid !== 1'b0) begin bad++; $display("FAIL l1_lat2 valid=%b exp=0", wif.w_valid); end
    cyc();
    for (int k = 0; k < 96; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(96 + k))) begin
        bad++; $display("FAIL l1_word k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(96 + k)));
      end
      total++; if (wif.w_idx !== 7'(k)) begin bad++; $display("FAIL l1_idx got=%0d exp=%0d", wif.w_idx, k); end
      total++; if (wif.w_last !== (k == 95)) begin bad++; $display("FAIL l1_last k=%0d got=%b", k, wif.w_last); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL l1_early_done k=%0d", k); end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL l1_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL l1_idle_busy got=%b exp=0", busy); end
    total++; if (rom_addr !== 16'd191) begin bad++; $display("FAIL l1_addr_hold got=%0d exp=191", rom_addr); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL l1_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_all_layers();
    start = 1'b1; layer_sel = 2'd3; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    total++; if (rom_addr !== 16'd0) begin bad++; $display("FAIL all_addr0 got=%0d exp=0", rom_addr); end
    cyc(); cyc();
    for (int k = 0; k < 288; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(k))) begin
        bad++; $display("FAIL all_word k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(k)));
      end
      total++; if (wif.w_idx !== 7'(k % 96)) begin bad++; $display("FAIL all_idx k=%0d got=%0d exp=%0d", k, wif.w_idx, k % 96); end
      total++; if (wif.w_last !== (k == 287)) begin bad++; $display("FAIL all_last k=%0d got=%b", k, wif.w_last); end
      total++; if (rom_addr > 16'd287) begin bad++; $display("FAIL all_addr_range got=%0d max=287", rom_addr); end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL all_done got=%b exp=1", done); end
    total++; if (rom_addr !== 16'd287) begin bad++; $display("FAIL all_addr_hold got=%0d exp=287", rom_addr); end
    cyc();
  endtask

  task automatic test_random_ready();
    int k = 0;
    int cycles = 0;
    start = 1'b1; layer_sel = 2'd0; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    while (k < 96 && cycles < 3000) begin
      wif.w_ready = 1'($urandom_range(0, 1));
      #1;
      if (wif.w_valid === 1'b1) begin
        total++; if (wif.w_data !== rom_fn(16'(k))) begin bad++; $display("FAIL rnd_word k=%0d got=%h exp=%h", k, wif.w_data, rom_fn(16'(k))); end
        total++; if (wif.w_idx !== 7'(k)) begin bad++; $display("FAIL rnd_idx got=%0d exp=%0d", wif.w_idx, k); end
        total++; if (wif.w_last !== (k == 95)) begin bad++; $display("FAIL rnd_last k=%0d got=%b", k, wif.w_last); end
      end
      total++; if (dut.fifo_count > 2) begin bad++; $display("FAIL rnd_fifo_count got=%0d max=2", dut.fifo_count); end
      if (wif.w_valid === 1'b1 && wif.w_ready === 1'b1) k++;
      cyc();
      cycles++;
    end
    total++; if (k != 96) begin bad++; $display("FAIL rnd_timeout words=%0d exp=96", k); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd_done got=%b exp=1", done); end
    wif.w_ready = 1'b1;
    cyc();
  endtask

  task automatic test_stall();
    start = 1'b1; layer_sel = 2'd2; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 20; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(192 + k))) begin
        bad++; $display("FAIL stall_pre k=%0d got=%h exp=%h", k, wif.w_data, rom_fn(16'(192 + k)));
      end
      cyc();
    end
    wif.w_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      #1;
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'd212)) begin
        bad++; $display("FAIL stall_hold_data s=%0d valid=%b got=%h exp=%h", s, wif.w_valid, wif.w_data, rom_fn(16'd212));
      end
      total++; if (wif.w_idx !== 7'd20 || wif.w_last !== 1'b0) begin bad++; $display("FAIL stall_hold_idx s=%0d idx=%0d last=%b exp=20,0", s, wif.w_idx, wif.w_last); end
      total++; if (rom_addr !== 16'd213) begin bad++; $display("FAIL stall_no_issue s=%0d addr=%0d exp=213", s, rom_addr); end
      cyc();
    end
    wif.w_ready = 1'b1;
    for (int k = 20; k < 96; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(192 + k))) begin
        bad++; $display("FAIL stall_resume k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(192 + k)));
      end
      total++; if (wif.w_idx !== 7'(k)) begin bad++; $display("FAIL stall_idx got=%0d exp=%0d", wif.w_idx, k); end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
    cyc();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; layer_sel = 2'd0; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 96; k++) begin
      if (k == 10) begin start = 1'b1; layer_sel = 2'd2; end
      if (k == 11) begin start = 1'b0; layer_sel = 2'd0; end
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(k))) begin
        bad++; $display("FAIL b2b_word k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(k)));
      end
      total++; if (wif.w_last !== (k == 95)) begin bad++; $display("FAIL b2b_last k=%0d got=%b", k, wif.w_last); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy k=%0d got=%b exp=1", k, busy); end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
    start = 1'b1; layer_sel = 2'd1;
    cyc();
    start = 1'b0;
    total++; if (rom_addr !== 16'd96 || busy !== 1'b1) begin bad++; $display("FAIL b2b_restart addr=%0d busy=%b exp=96,1", rom_addr, busy); end
    cyc(); cyc();
    for (int k = 0; k < 96; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(96 + k))) begin
        bad++; $display("FAIL b2b_second k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(96 + k)));
      end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    cyc();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; layer_sel = 2'd0; wif.w_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 40; k++) cyc();
    total++; if (wif.w_idx !== 7'd40 || wif.w_valid !== 1'b1) begin bad++; $display("FAIL mid_pre idx=%0d valid=%b exp=40,1", wif.w_idx, wif.w_valid); end
    rst_n = 1'b1;
    cyc();
    total++; if (wif.w_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", wif.w_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (rom_addr !== 16'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", rom_addr); end
    total++; if (wif.w_idx !== 7'd0 || wif.w_last !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_outs idx=%0d last=%b done=%b exp=0,0,0", wif.w_idx, wif.w_last, done); end
    rst_n = 1'b0;
    cyc();
    total++; if (wif.w_valid !== 1'b0) begin bad++; $display("FAIL mid_release valid=%b exp=0", wif.w_valid); end
    start = 1'b1; layer_sel = 2'd2;
    cyc();
    start = 1'b0;
    total++; if (rom_addr !== 16'd192) begin bad++; $display("FAIL mid_l2_addr got=%0d exp=192", rom_addr); end
    cyc(); cyc();
    for (int k = 0; k < 96; k++) begin
      total++;
      if (wif.w_valid !== 1'b1 || wif.w_data !== rom_fn(16'(192 + k))) begin
        bad++; $display("FAIL mid_l2_word k=%0d valid=%b got=%h exp=%h", k, wif.w_valid, wif.w_data, rom_fn(16'(192 + k)));
      end
      total++; if (wif.w_idx !== 7'(k) || wif.w_last !== (k == 95)) begin bad++; $display("FAIL mid_l2_idx k=%0d idx=%0d last=%b", k, wif.w_idx, wif.w_last); end
      cyc();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_l2_done got=%b exp=1", done); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_layer1();
    test_all_layers();
    test_random_ready();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
